cb_exec: RTL and testbench

Sequencer that executes one CB-prefixed SM83 instruction (rotate/shift/swap, BIT, RES, SET) once the front end has fetched the second opcode byte. It drives the operand path: a register operand comes from the register file, and an (HL) operand goes through a read/modify/write on the memory bus. It writes back the result and flags, then pulses done. It sits between the CPU control FSM, the register file and the bus interface.

---
 rtl/cb_pkg.sv | 40 ++++
 rtl/cb_shift_unit.sv | 33 +++
 rtl/cb_exec.sv | 157 +++++++++++++++
 tb/tb_cb_exec.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cb_pkg
// Brief    : Shared types and constants for the CB-prefix instruction sequencer.
// Revision : 1.0
// ============================================================================
package cb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_MEM_WR = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GRP_SHIFT = 2'd0,
        GRP_BIT   = 2'd1,
        GRP_RES   = 2'd2,
        GRP_SET   = 2'd3
    } group_t;

    typedef enum logic [2:0] {
        SH_RLC  = 3'd0,
        SH_RRC  = 3'd1,
        SH_RL   = 3'd2,
        SH_RR   = 3'd3,
        SH_SLA  = 3'd4,
        SH_SRA  = 3'd5,
        SH_SWAP = 3'd6,
        SH_SRL  = 3'd7
    } shift_op_t;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

endpackage : cb_pkg
`default_nettype wire

// File: rtl/cb_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : cb_shift_unit
// Brief    : Combinational rotate/shift/swap datapath for CB group 00.
// Revision : 1.0
// ============================================================================
module cb_shift_unit
    import cb_pkg::*;
(
    input  logic [7:0] a,
    input  logic [2:0] op,
    input  logic       cin,
    output logic [7:0] result,
    output logic       cout
);

    always_comb begin
        result = a;
        cout   = 1'b0;
        case (shift_op_t'(op))
            SH_RLC:  begin result = {a[6:0], a[7]};  cout = a[7]; end
            SH_RRC:  begin result = {a[0], a[7:1]};  cout = a[0]; end
            SH_RL:   begin result = {a[6:0], cin};   cout = a[7]; end
            SH_RR:   begin result = {cin, a[7:1]};   cout = a[0]; end
            SH_SLA:  begin result = {a[6:0], 1'b0};  cout = a[7]; end
            SH_SRA:  begin result = {a[7], a[7:1]};  cout = a[0]; end
            SH_SWAP: begin result = {a[3:0], a[7:4]}; cout = 1'b0; end
            SH_SRL:  begin result = {1'b0, a[7:1]};  cout = a[0]; end
        endcase
    end

endmodule : cb_shift_unit
`default_nettype wire

// File: rtl/cb_exec.sv
`default_nettype none
// ============================================================================
// Module   : cb_exec
// Brief    : Executes one CB-prefixed SM83 instruction on a register or (HL).
// Revision : 1.0
// ============================================================================
module cb_exec
    import cb_pkg::*;
#(
    parameter logic [2:0] MEM_OPERAND = 3'd6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic [7:0] reg_rdata,
    input  logic [7:0] f_in,
    output logic       busy,
    output logic       done,
    output logic       reg_we,
    output logic [2:0] reg_sel,
    output logic [7:0] reg_wdata,
    output logic       f_we,
    output logic [7:0] f_wdata,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack
);

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] operand_q, operand_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic [3:0] fhi_q, fhi_d;

    group_t     w_group;
    logic [2:0] w_bsel;
    logic [7:0] w_a, w_mask, w_shift_res, w_result, w_flags;
    logic       w_shift_cout, w_cin, w_is_mem, w_unused;

    assign w_group  = group_t'(op_q[7:6]);
    assign w_bsel   = op_q[5:3];
    assign w_is_mem = (op_q[2:0] == MEM_OPERAND);
    assign w_cin    = fhi_q[FLAG_C-4];
    assign w_mask   = 8'h01 << w_bsel;
    assign w_unused = ^f_in[3:0];

    // While the read is being acknowledged the operand comes straight off the
    // bus so the write data can be registered on the same edge.
    assign w_a = (state_q == ST_MEM_RD) ? mem_rdata : operand_q;

    cb_shift_unit u_shift (
        .a      (w_a),
        .op     (w_bsel),
        .cin    (w_cin),
        .result (w_shift_res),
        .cout   (w_shift_cout)
    );

    always_comb begin
        w_result = w_a;
        w_flags  = 8'h00;
        case (w_group)
            GRP_SHIFT: begin
                w_result        = w_shift_res;
                w_flags[FLAG_Z] = (w_shift_res == 8'h00);
                w_flags[FLAG_C] = w_shift_cout;
            end
            GRP_BIT: begin
                w_flags[FLAG_Z] = ~w_a[w_bsel];
                w_flags[FLAG_H] = 1'b1;
                w_flags[FLAG_C] = w_cin;
            end
            GRP_RES: begin
                w_result = w_a & ~w_mask;
                w_flags  = {fhi_q, 4'h0};
            end
            GRP_SET: begin
                w_result = w_a | w_mask;
                w_flags  = {fhi_q, 4'h0};
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        operand_d   = operand_q;
        fhi_d       = fhi_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = opcode;
                    fhi_d = f_in[7:4];
                    if (opcode[2:0] == MEM_OPERAND) begin
                        state_d = ST_MEM_RD;
                    end else begin
                        operand_d = reg_rdata;
                        state_d   = ST_FINISH;
                    end
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    operand_d = mem_rdata;
                    if (w_group == GRP_BIT) begin
                        state_d = ST_FINISH;
                    end else begin
                        mem_wdata_d = w_result;
                        state_d     = ST_MEM_WR;
                    end
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    mem_wdata_d = 8'h00;
                    state_d     = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 8'h00;
            operand_q   <= 8'h00;
            fhi_q       <= 4'h0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            operand_q   <= operand_d;
            fhi_q       <= fhi_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign reg_we    = done && !w_is_mem && (w_group != GRP_BIT);
    assign reg_sel   = op_q[2:0];
    assign reg_wdata = done ? w_result : 8'h00;
    assign f_we      = done && ((w_group == GRP_SHIFT) || (w_group == GRP_BIT));
    assign f_wdata   = done ? w_flags : 8'h00;
    assign mem_req   = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign mem_we    = (state_q == ST_MEM_WR);
    assign mem_wdata = mem_wdata_q;

endmodule : cb_exec
`default_nettype wire

// File: tb/tb_cb_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_cb_exec
// Brief    : Scoreboard bench for cb_exec with a simple acking memory model.
// Revision : 1.0
// ============================================================================
module tb_cb_exec;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] opcode, reg_rdata, f_in, mem_rdata;
    logic       mem_ack;
    logic       busy, done, reg_we, f_we, mem_req, mem_we;
    logic [2:0] reg_sel;
    logic [7:0] reg_wdata, f_wdata, mem_wdata;

    cb_exec #(.MEM_OPERAND(3'd6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .reg_rdata (reg_rdata),
        .f_in      (f_in),
        .busy      (busy),
        .done      (done),
        .reg_we    (reg_we),
        .reg_sel   (reg_sel),
        .reg_wdata (reg_wdata),
        .f_we      (f_we),
        .f_wdata   (f_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string      tag;
        int         due;
        logic       rwe;
        logic [2:0] sel;
        logic [7:0] rres;
        logic       fwe;
        logic [7:0] fres;
    } exp_t;

    exp_t sb[$];

    int         ack_delay = 0;
    logic [7:0] mem_val   = 8'h00;
    logic [7:0] exp_wdata = 8'h00;
    int         rd_cnt = 0, wr_cnt = 0, req_cnt = 0, wait_cnt = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: acks after ack_delay waiting cycles, throws spurious acks when idle
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req && !reset) begin
                req_cnt++;
                if (mem_we) chk("mem_wdata", {24'h0, mem_wdata}, {24'h0, exp_wdata});
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        wr_cnt++;
                        mem_rdata = 8'($urandom);
                    end else begin
                        rd_cnt++;
                        mem_rdata = mem_val;
                    end
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                    wait_cnt++;
                end
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = 8'($urandom);
                wait_cnt  = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.tag, "_cycle"}, cyc, e.due);
                        chk({e.tag, "_busy"}, {31'h0, busy}, 32'd1);
                        chk({e.tag, "_reg_we"}, {31'h0, reg_we}, {31'h0, e.rwe});
                        chk({e.tag, "_reg_sel"}, {29'h0, reg_sel}, {29'h0, e.sel});
                        if (e.rwe) chk({e.tag, "_reg_wdata"}, {24'h0, reg_wdata}, {24'h0, e.rres});
                        chk({e.tag, "_f_we"}, {31'h0, f_we}, {31'h0, e.fwe});
                        if (e.fwe) chk({e.tag, "_f_wdata"}, {24'h0, f_wdata}, {24'h0, e.fres});
                    end
                end else begin
                    chk("strobes_idle", {30'h0, reg_we, f_we}, 32'd0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {17'h0, busy, done, reg_we, reg_sel, reg_wdata, f_we, mem_req, mem_we},
            32'd0);
        chk({tag, "_data"}, {16'h0, f_wdata, mem_wdata}, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk({tag, "_drain"}, sb.size(), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic do_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] fin, input logic [7:0] mval, input int dly,
                         input logic rwe, input logic [7:0] rres, input logic fwe,
                         input logic [7:0] fres, input int exp_rd, input int exp_wr,
                         input logic [7:0] wdata, input int lat, input int glitch);
        int   rd0, wr0;
        exp_t e;
        rd0       = rd_cnt;
        wr0       = wr_cnt;
        ack_delay = dly;
        mem_val   = mval;
        exp_wdata = wdata;
        @(posedge clk);
        #1;
        opcode    = op;
        reg_rdata = a;
        f_in      = fin;
        start     = 1'b1;
        e.tag  = tag;
        e.due  = cyc + lat;
        e.rwe  = rwe;
        e.sel  = op[2:0];
        e.rres = rres;
        e.fwe  = fwe;
        e.fres = fres;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        opcode    = 8'($urandom);
        reg_rdata = 8'($urandom);
        f_in      = 8'($urandom);
        if (glitch > 0) begin
            repeat (glitch - 1) begin
                @(posedge clk);
                #1;
            end
            start     = 1'b1;
            opcode    = 8'h00;
            reg_rdata = 8'h55;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(tag);
        chk({tag, "_reads"}, rd_cnt - rd0, exp_rd);
        chk({tag, "_writes"}, wr_cnt - wr0, exp_wr);
    endtask

    function automatic void ref_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] fin,
                                   output logic [7:0] r, output logic [7:0] f,
                                   output logic fwe, output logic rwe);
        logic c, co;
        int   b;
        b   = int'(op[5:3]);
        c   = fin[4];
        co  = 1'b0;
        r   = a;
        f   = 8'h00;
        fwe = 1'b1;
        rwe = 1'b1;
        case (op[7:6])
            2'b00: begin
                case (op[5:3])
                    3'd0: begin r = {a[6:0], a[7]}; co = a[7]; end
                    3'd1: begin r = {a[0], a[7:1]}; co = a[0]; end
                    3'd2: begin r = {a[6:0], c};    co = a[7]; end
                    3'd3: begin r = {c, a[7:1]};    co = a[0]; end
                    3'd4: begin r = {a[6:0], 1'b0}; co = a[7]; end
                    3'd5: begin r = {a[7], a[7:1]}; co = a[0]; end
                    3'd6: begin r = {a[3:0], a[7:4]}; co = 1'b0; end
                    default: begin r = {1'b0, a[7:1]}; co = a[0]; end
                endcase
                f = {(r == 8'h00), 2'b00, co, 4'h0};
            end
            2'b01: begin
                rwe = 1'b0;
                f   = {~a[b], 1'b0, 1'b1, c, 4'h0};
            end
            2'b10: begin r[b] = 1'b0; fwe = 1'b0; end
            default: begin r[b] = 1'b1; fwe = 1'b0; end
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op, a, fin, r, f;
        logic       fwe, rwe;
        int         dly, rq0, wr0, n;
        reset     = 1'b1;
        start     = 1'b0;
        opcode    = 8'h00;
        reg_rdata = 8'h00;
        f_in      = 8'h00;
        repeat (3) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        rq0 = req_cnt;
        do_op("rlc_b",   8'h00, 8'h85, 8'h00, 8'h00, 0, 1'b1, 8'h0B, 1'b1, 8'h10, 0, 0, 8'h00, 1, 0);
        chk("rlc_b_no_req", req_cnt - rq0, 32'd0);
        do_op("swap_a",  8'h37, 8'hF0, 8'h00, 8'h00, 0, 1'b1, 8'h0F, 1'b1, 8'h00, 0, 0, 8'h00, 1, 0);
        do_op("sra_a",   8'h2F, 8'h81, 8'h00, 8'h00, 0, 1'b1, 8'hC0, 1'b1, 8'h10, 0, 0, 8'h00, 1, 0);
        do_op("swap_z",  8'h37, 8'h00, 8'hF0, 8'h00, 0, 1'b1, 8'h00, 1'b1, 8'h80, 0, 0, 8'h00, 1, 0);
        do_op("bit7_hl", 8'h7E, 8'h00, 8'h10, 8'h7F, 0, 1'b0, 8'h00, 1'b1, 8'hB0, 1, 0, 8'h00, 2, 0);
        do_op("set3_hl", 8'hDE, 8'h00, 8'h00, 8'h00, 2, 1'b0, 8'h00, 1'b0, 8'h00, 1, 1, 8'h08, 7, 0);
        do_op("rl_c",    8'h11, 8'h80, 8'h10, 8'h00, 0, 1'b1, 8'h01, 1'b1, 8'h10, 0, 0, 8'h00, 1, 0);
        // Start pulses while busy in MEM_RD, then in the FINISH cycle: both dropped
        do_op("rrc_hl_glitch", 8'h0E, 8'h00, 8'h00, 8'h01, 1, 1'b0, 8'h00, 1'b1, 8'h10, 1, 1, 8'h80, 5, 2);
        do_op("rlc_fin_glitch", 8'h00, 8'h01, 8'h00, 8'h00, 0, 1'b1, 8'h02, 1'b1, 8'h00, 0, 0, 8'h00, 1, 1);

        // Reset in the middle of the write phase of RES 0,(HL)
        ack_delay = 3;
        mem_val   = 8'hFF;
        exp_wdata = 8'hFE;
        @(posedge clk);
        #1;
        opcode = 8'h86;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        while (!mem_we && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("rst_reached_wr", {31'h0, mem_we}, 32'd1);
        wr0 = wr_cnt;
        rq0 = req_cnt;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid_wr");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("rst_no_write", wr_cnt - wr0, 32'd0);
        chk("rst_no_req", req_cnt - rq0, 32'd0);
        do_op("res0_hl_after_rst", 8'h86, 8'h00, 8'h00, 8'hFF, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1, 1, 8'hFE, 3, 0);

        for (int i = 0; i < 16; i++) begin
            op  = 8'($urandom);
            if (op[2:0] == 3'd6) op[2:0] = 3'd7;
            a   = 8'($urandom);
            fin = 8'($urandom);
            ref_op(op, a, fin, r, f, fwe, rwe);
            do_op($sformatf("rnd_reg%0d", i), op, a, fin, 8'h00, 0, rwe, r, fwe, f, 0, 0, 8'h00, 1, 0);
        end

        for (int i = 0; i < 8; i++) begin
            op  = 8'($urandom);
            op[2:0] = 3'd6;
            a   = 8'($urandom);
            fin = 8'($urandom);
            dly = int'($urandom_range(0, 2));
            ref_op(op, a, fin, r, f, fwe, rwe);
            if (op[7:6] == 2'b01)
                do_op($sformatf("rnd_hl%0d", i), op, 8'h00, fin, a, dly, 1'b0, 8'h00, fwe, f,
                      1, 0, 8'h00, 2 + dly, 0);
            else
                do_op($sformatf("rnd_hl%0d", i), op, 8'h00, fin, a, dly, 1'b0, 8'h00, fwe, f,
                      1, 1, r, 3 + 2 * dly, 0);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cb_exec
`default_nettype wire
